// File: rtl/dram_responder_if.sv
// DRAM strobe/address/data bundle between a RAS/CAS controller (master) and
// the emulated SIMM (slave).
interface dram_responder_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              RAS;
    logic              CAS;
    logic              WE;
    logic              OE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DQ_IN;
    logic [DATA_W-1:0] DQ_OUT;
    logic              DQ_OE;

    modport master (
        output RAS, CAS, WE, OE, ADDR, DQ_IN,
        input  DQ_OUT, DQ_OE
    );

    modport slave (
        input  RAS, CAS, WE, OE, ADDR, DQ_IN,
        output DQ_OUT, DQ_OE
    );
endinterface

// File: rtl/dram_responder.sv
// Single-bank DRAM emulator: decodes RAS/CAS cycles into block-RAM accesses,
// counts CBR and RAS-only refreshes, and flags interval and protocol faults.
module dram_responder #(
    parameter int ADDR_W             = 11,
    parameter int DATA_W             = 8,
    parameter int MEM_AW             = 12,
    parameter int REFRESH_MAX_CYCLES = 256
) (
    input  logic                CLK,
    input  logic                RST,
    dram_responder_if.slave     bus,
    output logic [15:0]         REFRESH_COUNT,
    output logic                REFRESH_VIOLATION,
    output logic                PROTO_ERR
);
    localparam int          HALF        = MEM_AW / 2;
    localparam logic [15:0] REFRESH_MAX = 16'(REFRESH_MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_OPEN,
        S_ACCESS,
        S_CBR,
        S_REFRESH,
        S_RECOVER
    } state_e;

    state_e              state_q, state_d;
    logic [HALF-1:0]     row_q, row_d;
    logic                rd_op_q, rd_op_d;
    logic [DATA_W-1:0]   dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic [15:0]         refresh_count_q, refresh_count_d;
    logic [15:0]         interval_q, interval_d;
    logic [15:0]         interval_inc;
    logic                violation_q, violation_d;
    logic                proto_q, proto_d;

    logic                refresh_evt;
    logic                proto_set;
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_idx;
    logic                r, c;

    logic [DATA_W-1:0]   mem [0:2**MEM_AW-1];

    // Row/column bits above MEM_AW/2 alias and are deliberately ignored.
    logic addr_hi_unused;
    generate
        if (HALF < ADDR_W) begin : g_alias
            assign addr_hi_unused = ^bus.ADDR[ADDR_W-1:HALF];
        end else begin : g_no_alias
            assign addr_hi_unused = 1'b0;
        end
    endgenerate

    assign r       = bus.RAS;
    assign c       = bus.CAS;
    assign mem_idx = {row_q, bus.ADDR[HALF-1:0]};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d         = state_q;
        row_d           = row_q;
        rd_op_d         = rd_op_q;
        dq_out_d        = dq_out_q;
        refresh_evt     = 1'b0;
        proto_set       = 1'b0;
        mem_we          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!r && c) begin
                    row_d   = bus.ADDR[HALF-1:0];
                    state_d = S_ROW_OPEN;
                end else if (r && !c) begin
                    state_d = S_CBR;
                end else if (!r && !c) begin
                    proto_set = 1'b1;
                    state_d   = S_RECOVER;
                end
            end
            S_ROW_OPEN: begin
                if (r) begin
                    refresh_evt = 1'b1;
                    state_d     = S_IDLE;
                end else if (!c) begin
                    state_d = S_ACCESS;
                    rd_op_d = bus.WE;
                    if (!bus.WE) mem_we   = 1'b1;
                    else         dq_out_d = mem[mem_idx];
                end
            end
            S_ACCESS: begin
                if (r && c) begin
                    state_d = S_IDLE;
                end else if (!r && c) begin
                    state_d = S_ROW_OPEN;
                end else if (r && !c) begin
                    proto_set = 1'b1;
                    state_d   = S_RECOVER;
                end
            end
            S_CBR: begin
                if (!r && !c) begin
                    refresh_evt = 1'b1;
                    state_d     = S_REFRESH;
                end else if (r && c) begin
                    proto_set = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_REFRESH: begin
                if (r && c) begin
                    state_d = S_IDLE;
                end else if (r && !c) begin
                    state_d = S_CBR;
                end else if (!r && c) begin
                    proto_set = 1'b1;
                    state_d   = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (r && c) state_d = S_IDLE;
            end
            default: state_d = S_RECOVER;
        endcase
    end

    // Drive enable tracks OE live for the whole time a read stays in ACCESS.
    assign dq_oe_d = (state_d == S_ACCESS) && rd_op_d && !bus.OE;

    assign refresh_count_d = (refresh_evt && refresh_count_q != 16'hFFFF)
                             ? refresh_count_q + 16'd1 : refresh_count_q;

    // A refresh landing on the limit clock wins: counts as a clear, no violation.
    assign interval_inc = (interval_q == 16'hFFFF) ? interval_q : interval_q + 16'd1;
    assign interval_d   = refresh_evt ? 16'd0 : interval_inc;
    assign violation_d  = violation_q | (!refresh_evt && interval_inc >= REFRESH_MAX);
    assign proto_d      = proto_q | proto_set;

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q         <= S_RECOVER;
            row_q           <= '0;
            rd_op_q         <= 1'b0;
            dq_out_q        <= '0;
            dq_oe_q         <= 1'b0;
            refresh_count_q <= '0;
            interval_q      <= '0;
            violation_q     <= 1'b0;
            proto_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            rd_op_q         <= rd_op_d;
            dq_out_q        <= dq_out_d;
            dq_oe_q         <= dq_oe_d;
            refresh_count_q <= refresh_count_d;
            interval_q      <= interval_d;
            violation_q     <= violation_d;
            proto_q         <= proto_d;
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM and keeps contents across RST.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) mem[mem_idx] <= bus.DQ_IN;
    end

    assign bus.DQ_OUT        = dq_out_q;
    assign bus.DQ_OE         = dq_oe_q;
    assign REFRESH_COUNT     = refresh_count_q;
    assign REFRESH_VIOLATION = violation_q;
    assign PROTO_ERR         = proto_q;
endmodule

// File: tb/tb_dram_responder.sv
// Directed and randomized bench for dram_responder with a transaction-level
// reference model (word array, refresh tally, clocks-since-refresh).
module tb_dram_responder;
    localparam int REF_MAX = 256;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] REFRESH_COUNT;
    logic        REFRESH_VIOLATION;
    logic        PROTO_ERR;

    dram_responder_if #(.ADDR_W(11), .DATA_W(8)) bus ();

    dram_responder #(
        .ADDR_W(11), .DATA_W(8), .MEM_AW(12), .REFRESH_MAX_CYCLES(REF_MAX)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .bus               (bus.slave),
        .REFRESH_COUNT     (REFRESH_COUNT),
        .REFRESH_VIOLATION (REFRESH_VIOLATION),
        .PROTO_ERR         (PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [0:4095];
    int unsigned m_written [$];
    int unsigned m_count;
    int unsigned m_since;
    bit          m_viol;
    bit          m_proto;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned idx_of(input logic [10:0] row, input logic [10:0] col);
        return {20'd0, row[5:0], col[5:0]};
    endfunction

    // One clock; the model advances with the same edge the DUT sees.
    task automatic tick(input bit refresh_edge);
        @(posedge CLK);
        if (RST) begin
            m_count = 0; m_since = 0; m_viol = 0; m_proto = 0;
        end else if (refresh_edge) begin
            m_since = 0;
            if (m_count < 32'hFFFF) m_count++;
        end else begin
            if (m_since < 32'hFFFF) m_since++;
            if (m_since >= REF_MAX) m_viol = 1;
        end
        @(negedge CLK);
    endtask

    task automatic set_bus(input logic r, input logic c, input logic we, input logic oe,
                           input logic [10:0] a, input logic [7:0] d);
        bus.RAS = r; bus.CAS = c; bus.WE = we; bus.OE = oe; bus.ADDR = a; bus.DQ_IN = d;
    endtask

    task automatic idle(input int n);
        set_bus(1, 1, 1, 1, 11'h0, 8'h0);
        for (int i = 0; i < n; i++) tick(0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
        idle(1);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(REFRESH_COUNT), m_count);
        check({tag, ".viol"},  32'(REFRESH_VIOLATION), 32'(m_viol));
        check({tag, ".proto"}, 32'(PROTO_ERR), 32'(m_proto));
    endtask

    task automatic write_word(input logic [10:0] row, input logic [10:0] col, input logic [7:0] d);
        set_bus(0, 1, 1, 1, row, 8'h0); tick(0);
        set_bus(0, 0, 0, 1, col, d);    tick(0);
        m_mem[idx_of(row, col)] = d;
        m_written.push_back(idx_of(row, col));
        check("write.dq_oe", 32'(bus.DQ_OE), 0);
        idle(1);
    endtask

    task automatic read_word(input logic [10:0] row, input logic [10:0] col,
                             input logic [7:0] exp, input string tag);
        set_bus(0, 1, 1, 0, row, 8'h0); tick(0);
        set_bus(0, 0, 1, 0, col, 8'h0); tick(0);
        check({tag, ".dq_out"}, 32'(bus.DQ_OUT), 32'(exp));
        check({tag, ".dq_oe"},  32'(bus.DQ_OE), 1);
        idle(1);
        check({tag, ".dq_oe_off"}, 32'(bus.DQ_OE), 0);
        check({tag, ".dq_hold"},   32'(bus.DQ_OUT), 32'(exp));
    endtask

    task automatic cbr_refresh();
        set_bus(1, 0, 1, 1, 11'h0, 8'h0); tick(0);
        set_bus(0, 0, 1, 1, 11'h0, 8'h0); tick(1);
        idle(1);
    endtask

    task automatic ras_only_refresh(input logic [10:0] row);
        set_bus(0, 1, 1, 1, row, 8'h0); tick(0);
        idle(1);
        // The refresh is the edge that sampled RAS high; redo that bookkeeping.
        m_since = 0;
        if (m_count < 32'hFFFF) m_count++;
    endtask

    // Two writes in one RAS-low period using fast-page CAS cycling.
    task automatic page_write(input logic [10:0] row, input logic [10:0] ca, input logic [10:0] cb,
                              input logic [7:0] da, input logic [7:0] db);
        set_bus(0, 1, 1, 1, row, 8'h0); tick(0);
        set_bus(0, 0, 0, 1, ca, da);    tick(0);
        m_mem[idx_of(row, ca)] = da;
        set_bus(0, 1, 1, 1, ca, 8'h0);  tick(0);
        set_bus(0, 0, 0, 1, cb, db);    tick(0);
        m_mem[idx_of(row, cb)] = db;
        m_written.push_back(idx_of(row, ca));
        m_written.push_back(idx_of(row, cb));
        idle(1);
    endtask

    initial begin
        logic [7:0]  d, d2;
        logic [10:0] row, col, col2;
        int unsigned pick;

        set_bus(1, 1, 1, 1, 11'h0, 8'h0);
        m_count = 0; m_since = 0; m_viol = 0; m_proto = 0;

        // Reset values.
        RST = 1'b1;
        idle(2);
        check("rst.dq_out", 32'(bus.DQ_OUT), 0);
        check("rst.dq_oe",  32'(bus.DQ_OE), 0);
        check("rst.count",  32'(REFRESH_COUNT), 0);
        check("rst.viol",   32'(REFRESH_VIOLATION), 0);
        check("rst.proto",  32'(PROTO_ERR), 0);
        RST = 1'b0;
        idle(1);

        // Refresh landing exactly on clock 256 after reset: no violation.
        idle(253);
        cbr_refresh();
        check("interval.edge_ok", 32'(REFRESH_VIOLATION), 0);
        check_status("interval.edge_ok");

        // One clock later: violation, which then survives a refresh.
        do_reset();
        idle(254);
        cbr_refresh();
        check("interval.late", 32'(REFRESH_VIOLATION), 1);
        cbr_refresh();
        check("interval.sticky", 32'(REFRESH_VIOLATION), 1);
        check_status("interval.sticky");

        // Three CBR refreshes.
        do_reset();
        for (int i = 0; i < 3; i++) cbr_refresh();
        check("cbr3.count", 32'(REFRESH_COUNT), 3);
        check_status("cbr3");

        // Write then read; alias through row bit 6.
        write_word(11'h012, 11'h034, 8'hA5);
        read_word(11'h012, 11'h034, 8'hA5, "wr_rd");
        write_word(11'h040, 11'h000, 8'h3C);
        read_word(11'h000, 11'h000, 8'h3C, "alias");
        check_status("wr_rd");

        // OE toggled while a read holds ACCESS.
        set_bus(0, 1, 1, 0, 11'h012, 8'h0); tick(0);
        set_bus(0, 0, 1, 1, 11'h034, 8'h0); tick(0);
        check("oe_high.dq_oe", 32'(bus.DQ_OE), 0);
        set_bus(0, 0, 1, 0, 11'h034, 8'h0); tick(0);
        check("oe_low.dq_oe", 32'(bus.DQ_OE), 1);
        check("oe_low.dq_out", 32'(bus.DQ_OUT), 32'h0A5);
        idle(1);

        // RAS and CAS fall together: error, strobes ignored until both high.
        do_reset();
        write_word(11'h005, 11'h005, 8'h11);
        set_bus(0, 0, 0, 0, 11'h005, 8'hEE); tick(0);
        m_proto = 1;
        check("proto_both.err", 32'(PROTO_ERR), 1);
        tick(0);
        check("proto_both.dq_oe", 32'(bus.DQ_OE), 0);
        set_bus(0, 1, 0, 0, 11'h005, 8'hEE); tick(0);
        set_bus(0, 0, 0, 0, 11'h005, 8'hEE); tick(0);
        idle(1);
        read_word(11'h005, 11'h005, 8'h11, "proto_both.nowrite");
        check_status("proto_both");

        // CAS low then released without RAS.
        do_reset();
        set_bus(1, 0, 1, 1, 11'h0, 8'h0); tick(0);
        idle(1);
        m_proto = 1;
        check("proto_cas.err", 32'(PROTO_ERR), 1);
        check_status("proto_cas");

        // Reset while a read holds ACCESS.
        do_reset();
        write_word(11'h007, 11'h009, 8'h5A);
        set_bus(0, 1, 1, 0, 11'h007, 8'h0); tick(0);
        set_bus(0, 0, 1, 0, 11'h009, 8'h0); tick(0);
        check("midrst.pre_dq_oe", 32'(bus.DQ_OE), 1);
        RST = 1'b1;
        set_bus(0, 0, 0, 0, 11'h009, 8'hFF); tick(0);
        check("midrst.dq_out", 32'(bus.DQ_OUT), 0);
        check("midrst.dq_oe",  32'(bus.DQ_OE), 0);
        check_status("midrst");
        RST = 1'b0;
        tick(0);
        set_bus(0, 1, 0, 0, 11'h007, 8'hFF); tick(0);
        set_bus(0, 0, 0, 0, 11'h009, 8'hFF); tick(0);
        check("midrst.recover_dq_oe", 32'(bus.DQ_OE), 0);
        idle(1);
        read_word(11'h007, 11'h009, 8'h5A, "midrst.readback");
        check_status("midrst.after");

        // Randomized legal traffic against the model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            row  = 11'($urandom);
            col  = 11'($urandom);
            col2 = 11'($urandom);
            d    = 8'($urandom);
            d2   = 8'($urandom);
            case ($urandom_range(0, 5))
                0: write_word(row, col, d);
                1: begin
                    if (m_written.size() == 0) begin
                        write_word(row, col, d);
                    end else begin
                        pick = m_written[$urandom_range(0, m_written.size() - 1)];
                        row  = {5'($urandom), 6'(pick >> 6)};
                        col  = {5'($urandom), 6'(pick)};
                        read_word(row, col, m_mem[pick], "rand.read");
                    end
                end
                2: cbr_refresh();
                3: ras_only_refresh(row);
                4: idle($urandom_range(1, 40));
                default: begin
                    if (col2[5:0] == col[5:0]) col2[0] = ~col2[0];
                    page_write(row, col, col2, d, d2);
                    read_word(row, col, m_mem[idx_of(row, col)], "rand.page_a");
                end
            endcase
            check_status("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
